channel_add_arbiter: RTL and testbench
======================================

Name: channel_add_arbiter

Overview:
Shares one pipelined add-by-constant channel among NUM_REQ independent valid/ready requesters. Each cycle a round-robin arbiter picks at most one requester. The winner's word passes through a LATENCY-stage adder pipeline that carries a requester-ID tag. Results leave on a single response channel with backpressure, tagged with the originating ID. The block sits between client channels and the shared pipelined add datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 16, data width of requests and results
ADD_CONST, 2, constant added to every accepted word
LATENCY, 1, pipeline register stages from accept to response (1..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester valid
req_data  in  NUM_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
req_ready  out  NUM_REQ  one-hot or zero; grant this cycle
resp_valid  out  1  response word valid
resp_data  out  WIDTH  result word
resp_id  out  clog2(NUM_REQ)  originating requester index
resp_ready  in  1  downstream accepts response

Behaviour:
- Reset (rst=1, asynchronous): all pipeline valid bits 0, resp_valid=0, resp_data=0, resp_id=0, req_ready=0, RR pointer=0 (requester 0 highest priority). Reset mid-operation discards all in-flight words; no response is emitted for them.
- Pipeline advance: adv = ~resp_valid | resp_ready. When adv=0, every stage holds and req_ready=0.
- Arbitration (combinational): when adv=1, req_ready has exactly one bit set, for the first requester with req_valid=1 scanning from ptr upward with wrap-around. req_ready=0 if no requester is valid. req_ready never depends on its own requester's req_valid for any other index.
- Transfer: a word is accepted on the rising edge where req_valid[i] & req_ready[i]. On accept, ptr <= (i+1) mod NUM_REQ. With no accept, ptr holds.
- Arithmetic: result = (data + ADD_CONST) mod 2^WIDTH. Wrap-around is silent, with no flag. The addition happens in stage 1.
- Latency: a word accepted at edge k appears on resp_* right after edge k+LATENCY-1 (LATENCY=1 means visible after the accepting edge), provided there is no stall. Each stall cycle delays it by one.
- Output hold: when resp_valid=0, resp_data and resp_id keep their last valid values and do not track the input.
- Under stall, resp_valid/resp_data/resp_id stay stable until resp_ready=1.
- Throughput is one word per cycle when resp_ready stays high. Ordering is preserved and there is no reordering or drop.
- Simultaneous events: if a response handshake and a new accept occur on the same edge, the pipeline shifts and both complete.
- No state machine beyond the RR pointer and per-stage valid bits.

Decomposition:
- Package channel_add_pkg: ID_W = clog2(NUM_REQ) helper, default WIDTH/ADD_CONST/LATENCY constants, and a stage typedef {valid, id, data}.
- Sub-module rr_arbiter (NUM_REQ): inputs req, ptr, en; outputs one-hot gnt and encoded gnt_idx.
- The top level holds the pointer, the adder and the stage registers.

Test Plan:
1. Reset, then req_valid=0001, data0=10, resp_ready=1, clock once -> resp_valid=1, resp_data=12, resp_id=0. Next cycle with no request -> resp_valid=0, resp_data holds 12.
2. All four requesters valid with data 100,200,300,400, held for 4 cycles -> grants in order 0,1,2,3. Responses 102,202,302,402 with ids 0,1,2,3, back-to-back.
3. Fairness: requesters 1 and 3 continuously valid -> grants alternate 1,3,1,3. Neither is granted twice in a row.
4. Stall: with a response pending, hold resp_ready=0 for 3 cycles -> req_ready=0 and resp_data/resp_id stable throughout. Raising resp_ready resumes with no loss or duplication.
5. Overflow: data=16'hFFFF from requester 2 -> resp_data=16'h0001, resp_id=2.
6. Assert rst mid-stream with words in flight (LATENCY=3 build) -> resp_valid drops immediately and no stale responses appear after release. The first post-reset grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/channel_add_pkg.sv
// Shared definitions for the channel add arbiter: default build constants,
// the requester-index width helper and the pipeline stage layout.
package channel_add_pkg;

    localparam int unsigned DEFAULT_NUM_REQ   = 4;
    localparam int unsigned DEFAULT_WIDTH     = 16;
    localparam int unsigned DEFAULT_ADD_CONST = 2;
    localparam int unsigned DEFAULT_LATENCY   = 1;

    // Width of a requester index; never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    localparam int unsigned DEFAULT_ID_W = id_width(DEFAULT_NUM_REQ);

    // Stage payload for the default build; the top re-declares it at its own widths.
    typedef struct packed {
        logic                      valid;
        logic [DEFAULT_ID_W-1:0]   id;
        logic [DEFAULT_WIDTH-1:0]  data;
    } stage_t;

endpackage

// File: rtl/channel_add_arbiter_rr_arbiter.sv
// Round-robin grant selection.
// Ports:
//   req      in   NUM_REQ  request vector
//   ptr      in   ID_W     highest-priority index this cycle
//   en       in   1        grant enable; no grant when low
//   gnt      out  NUM_REQ  one-hot grant or zero (combinational)
//   gnt_idx  out  ID_W     encoded grant index (0 when no grant)
module rr_arbiter
    import channel_add_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]              req,
    input  logic [id_width(NUM_REQ)-1:0]    ptr,
    input  logic                            en,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [id_width(NUM_REQ)-1:0]    gnt_idx
);

    localparam int unsigned ID_W = id_width(NUM_REQ);

    logic            found;
    logic [ID_W-1:0] cand;

    // Scan from ptr upward with wrap-around; first valid requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/channel_add_arbiter.sv
// Shares one pipelined add-by-constant channel among NUM_REQ requesters.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   req_valid    in   NUM_REQ        per-requester valid
//   req_data     in   NUM_REQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
//   req_ready    out  NUM_REQ        one-hot grant or zero (combinational)
//   resp_valid   out  1              response valid
//   resp_data    out  WIDTH          data + ADD_CONST (mod 2^WIDTH)
//   resp_id      out  ID_W           originating requester index
//   resp_ready   in   1              downstream accepts response
module channel_add_arbiter
    import channel_add_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEFAULT_NUM_REQ,
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned ADD_CONST = DEFAULT_ADD_CONST,
    parameter int unsigned LATENCY   = DEFAULT_LATENCY
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]        req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            resp_valid,
    output logic [WIDTH-1:0]                resp_data,
    output logic [id_width(NUM_REQ)-1:0]    resp_id,
    input  logic                            resp_ready
);

    localparam int unsigned ID_W = id_width(NUM_REQ);

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
    } pipe_stage_t;

    pipe_stage_t        stg [LATENCY];
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    next_ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               adv;
    logic               accept;
    logic [WIDTH-1:0]   win_data;
    logic [WIDTH-1:0]   sum;

    // Whole pipeline moves only when the output slot is free or being drained.
    assign adv = ~stg[LATENCY-1].valid | resp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (adv),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign win_data  = req_data[32'(gnt_idx)*WIDTH +: WIDTH];
    assign sum       = WIDTH'(win_data + WIDTH'(ADD_CONST));
    assign next_ptr  = ID_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);

    // Pointer and stage registers; payload only loads behind a valid word so
    // the output keeps its last valid values across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            for (int unsigned s = 0; s < LATENCY; s++) begin
                stg[s] <= '0;
            end
        end else begin
            if (accept) begin
                ptr <= next_ptr;
            end
            if (adv) begin
                stg[0].valid <= accept;
                if (accept) begin
                    stg[0].id   <= gnt_idx;
                    stg[0].data <= sum;
                end
                for (int unsigned s = 1; s < LATENCY; s++) begin
                    stg[s].valid <= stg[s-1].valid;
                    if (stg[s-1].valid) begin
                        stg[s].id   <= stg[s-1].id;
                        stg[s].data <= stg[s-1].data;
                    end
                end
            end
        end
    end

    assign resp_valid = stg[LATENCY-1].valid;
    assign resp_data  = stg[LATENCY-1].data;
    assign resp_id    = stg[LATENCY-1].id;

endmodule

// File: tb/tb_channel_add_arbiter.sv
// Directed bench for channel_add_arbiter: a LATENCY=1 instance for the
// functional scenarios and a LATENCY=3 instance for in-flight reset.
module tb_channel_add_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 16;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR*W-1:0] req_data;
    logic          resp_ready;

    logic [NR-1:0] req_ready;
    logic          resp_valid;
    logic [W-1:0]  resp_data;
    logic [1:0]    resp_id;

    logic [NR-1:0] req_ready3;
    logic          resp_valid3;
    logic [W-1:0]  resp_data3;
    logic [1:0]    resp_id3;

    int checks = 0;
    int errors = 0;

    channel_add_arbiter #(
        .NUM_REQ(NR), .WIDTH(W), .ADD_CONST(2), .LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_id(resp_id), .resp_ready(resp_ready)
    );

    channel_add_arbiter #(
        .NUM_REQ(NR), .WIDTH(W), .ADD_CONST(2), .LATENCY(3)
    ) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready3), .resp_valid(resp_valid3), .resp_data(resp_data3),
        .resp_id(resp_id3), .resp_ready(resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        req_data = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        resp_ready = 1'b1;
        #3;
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== '0 || resp_id !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_l1 valid=%b data=%h id=%0d ready=%b expected 0/0/0/0",
                     resp_valid, resp_data, resp_id, req_ready);
        end
        checks++;
        if (resp_valid3 !== 1'b0 || resp_data3 !== '0 || resp_id3 !== '0) begin
            errors++;
            $display("FAIL reset_l3 valid=%b data=%h id=%0d expected 0/0/0",
                     resp_valid3, resp_data3, resp_id3);
        end
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        set_data(16'd10, 16'd0, 16'd0, 16'd0);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant got=%b expected=0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 16'd12 || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL single_resp valid=%b data=%0d id=%0d expected 1/12/0",
                     resp_valid, resp_data, resp_id);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 16'd12) begin
            errors++;
            $display("FAIL single_hold valid=%b data=%0d expected 0/12", resp_valid, resp_data);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_data(16'd100, 16'd200, 16'd300, 16'd400);
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << k)) begin
                errors++;
                $display("FAIL b2b_grant%0d got=%b expected=%b", k, req_ready, 4'(1 << k));
            end
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 16'(100*(k+1)+2) || resp_id !== 2'(k)) begin
                errors++;
                $display("FAIL b2b_resp%0d valid=%b data=%0d id=%0d expected 1/%0d/%0d",
                         k, resp_valid, resp_data, resp_id, 100*(k+1)+2, k);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_id;
        set_data(16'd0, 16'd5, 16'd0, 16'd7);
        req_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            exp_id = (k % 2 == 0) ? 2'd1 : 2'd3;
            #1;
            checks++;
            if (req_ready !== 4'(1 << exp_id)) begin
                errors++;
                $display("FAIL fair_grant%0d got=%b expected=%b", k, req_ready, 4'(1 << exp_id));
            end
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== exp_id ||
                resp_data !== ((exp_id == 2'd1) ? 16'd7 : 16'd9)) begin
                errors++;
                $display("FAIL fair_resp%0d valid=%b data=%0d id=%0d expected id %0d",
                         k, resp_valid, resp_data, resp_id, exp_id);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_stall();
        set_data(16'd50, 16'd60, 16'd0, 16'd0);
        req_valid = 4'b0001;
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 16'd52 || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL stall_setup valid=%b data=%0d id=%0d expected 1/52/0",
                     resp_valid, resp_data, resp_id);
        end
        resp_ready = 1'b0;
        req_valid  = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready%0d got=%b expected=0000", k, req_ready);
            end
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 16'd52 || resp_id !== 2'd0) begin
                errors++;
                $display("FAIL stall_hold%0d valid=%b data=%0d id=%0d expected 1/52/0",
                         k, resp_valid, resp_data, resp_id);
            end
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_resume_grant got=%b expected=0010", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 16'd62 || resp_id !== 2'd1) begin
            errors++;
            $display("FAIL stall_resume valid=%b data=%0d id=%0d expected 1/62/1",
                     resp_valid, resp_data, resp_id);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 16'd62) begin
            errors++;
            $display("FAIL stall_drain valid=%b data=%0d expected 0/62", resp_valid, resp_data);
        end
    endtask

    task automatic test_overflow();
        set_data(16'd0, 16'd0, 16'hFFFF, 16'd0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 16'h0001 || resp_id !== 2'd2) begin
            errors++;
            $display("FAIL overflow valid=%b data=%h id=%0d expected 1/0001/2",
                     resp_valid, resp_data, resp_id);
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        set_data(16'd1000, 16'd1001, 16'd1002, 16'd1003);
        req_valid = 4'b1111;
        tick();
        tick();
        checks++;
        if (resp_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL l3_latency_early valid=%b expected 0", resp_valid3);
        end
        tick();
        checks++;
        if (resp_valid3 !== 1'b1 || resp_data3 !== 16'd1002 || resp_id3 !== 2'd0) begin
            errors++;
            $display("FAIL l3_first valid=%b data=%0d id=%0d expected 1/1002/0",
                     resp_valid3, resp_data3, resp_id3);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid3 !== 1'b0 || resp_data3 !== '0 || resp_id3 !== '0) begin
            errors++;
            $display("FAIL l3_async_reset valid=%b data=%0d id=%0d expected 0/0/0",
                     resp_valid3, resp_data3, resp_id3);
        end
        req_valid = '0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (resp_valid3 !== 1'b0) begin
                errors++;
                $display("FAIL l3_stale%0d valid=%b expected 0", k, resp_valid3);
            end
        end
        set_data(16'd500, 16'd600, 16'd700, 16'd800);
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready3 !== 4'b0001) begin
            errors++;
            $display("FAIL l3_post_reset_grant got=%b expected=0001", req_ready3);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (resp_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL l3_post_early valid=%b expected 0", resp_valid3);
        end
        tick();
        checks++;
        if (resp_valid3 !== 1'b1 || resp_data3 !== 16'd502 || resp_id3 !== 2'd0) begin
            errors++;
            $display("FAIL l3_post_resp valid=%b data=%0d id=%0d expected 1/502/0",
                     resp_valid3, resp_data3, resp_id3);
        end
        tick();
        checks++;
        if (resp_valid3 !== 1'b0 || resp_data3 !== 16'd502) begin
            errors++;
            $display("FAIL l3_post_hold valid=%b data=%0d expected 0/502", resp_valid3, resp_data3);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_stall();
        test_overflow();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
